scan_cfg_loader: RTL and testbench
==================================

// Module: scan_cfg_loader
// PURPOSE
//  Sequences configuration load into config_module's serial scan chain from a host byte stream (valid/ready).
//  Pulses scan_reset, serialises bytes onto scan_in/scan_en and holds the enforcement core in reset until the chain is full.
//  Sits between the host/bus interface and top's scan_in/scan_en/scan_reset pins.
// PARAMETERS
//  CHAIN_BITS  1144  total scan-chain length in bits (MEM_LEN*8 + 120 config bits)
//  SHIFT_DIV   1     clk cycles per shifted bit (>=1)
//  CNT_BITS    11    width of bit counter; must satisfy 2**CNT_BITS > CHAIN_BITS
// PORTS
//  clk             in   1  system clock
//  reset           in   1  asynchronous, active-low reset
//  start           in   1  one-cycle pulse: begin a full chain load
//  in_data         in   8  config byte from host
//  in_valid        in   1  in_data valid
//  in_ready        out  1  loader accepts in_data this cycle
//  cfg_scan_reset  out  1  to config_module scan_reset
//  cfg_scan_en     out  1  to config_module scan_en (one-cycle shift strobe)
//  cfg_scan_in     out  1  to config_module scan_in
//  cfg_scan_out    in   1  from config_module scan_out
//  core_reset      out  1  active-high reset to core datapath/controller
//  busy            out  1  load (or verify) in progress
//  done            out  1  one-cycle pulse: load complete
//  err             out  1  sticky verify mismatch (0 without SCAN_VERIFY_EN)
// BEHAVIOUR
//  Reset (reset=0, any time, incl. mid-load): state IDLE; in_ready=0, cfg_scan_reset=0, cfg_scan_en=0,
//   cfg_scan_in=0, core_reset=1, busy=0, done=0, err=0; counters cleared. All outputs registered.
//  States: IDLE -> CLEAR -> WAIT_BYTE <-> SHIFT -> [VERIFY] -> FINISH -> IDLE.
//  IDLE: busy=0. start=1 -> CLEAR, core_reset:=1, err:=0. start ignored in any other state.
//  CLEAR: cfg_scan_reset=1 for exactly 2 cycles, bit counter:=0, then WAIT_BYTE.
//  WAIT_BYTE: in_ready=1; in_valid&in_ready -> latch in_data into shift byte, next cycle SHIFT.
//   in_valid outside WAIT_BYTE is not consumed (no handshake, data not lost by host).
//  SHIFT: bits sent LSB first; cfg_scan_in held for SHIFT_DIV cycles per bit, cfg_scan_en=1 on last cycle of
//   each bit period only; bit counter += 1 per strobe.
//   After 8th bit -> WAIT_BYTE; throughput 1 + 8*SHIFT_DIV cycles/byte with in_valid held high.
//  Bit counter == CHAIN_BITS after a strobe -> leave SHIFT immediately; remaining bits of that byte discarded.
//  FINISH: done=1 for 1 cycle, core_reset:=0 same cycle, busy:=0 next cycle -> IDLE.
//  core_reset stays 0 in IDLE until next start; reasserted on start or reset.
//  busy=1 in every state except IDLE.
// CONFIGURATION
//  SCAN_VERIFY_EN defined:
//   CRC-8 (poly 0x07, init 0x00) accumulated over every bit strobed in during SHIFT.
//   After last bit -> VERIFY: CHAIN_BITS strobes (same SHIFT_DIV timing) with cfg_scan_in=cfg_scan_out
//    (recirculate, chain contents preserved); second CRC-8 over cfg_scan_out sampled at each strobe.
//   CRC mismatch -> err:=1 (sticky until next start or reset); FINISH entered either way.
//   core_reset released only if err=0; if err=1, core_reset stays 1.
//  SCAN_VERIFY_EN undefined: no VERIFY state, no CRC logic, err tied 0, SHIFT -> FINISH directly.
// TESTING
//  T1 CHAIN_BITS=16, SHIFT_DIV=1: start, bytes 0xA5,0x3C back-to-back -> cfg_scan_in 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0
//     on 16 scan_en strobes; done pulses once; core_reset 1->0 at done.
//  T2 CHAIN_BITS=12: bytes 0xFF,0x0F -> exactly 12 strobes, last 4 bits of 0x0F dropped; WAIT_BYTE not re-entered.
//  T3 SHIFT_DIV=3: one byte -> scan_en high every 3rd cycle, 8 strobes in 24 cycles; in_ready low throughout.
//  T4 reset=0 during 5th bit of byte 2 -> all outputs at reset values next edge; new start reloads cleanly.
//  T5 start pulsed during SHIFT, in_valid held in SHIFT -> both ignored; byte accepted only in WAIT_BYTE.
//  T6 SCAN_VERIFY_EN, chain model corrupts one bit -> err=1, core_reset stays 1; clean model -> err=0, release.

Source files
------------

// File: rtl/scan_cfg_loader_if.sv
// Host byte-stream channel into scan_cfg_loader.
// A byte transfers on a rising clk edge where in_valid and in_ready are both high;
// the host holds in_data/in_valid stable until that edge, and the loader never waits on in_valid to raise in_ready.
interface scan_cfg_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/scan_cfg_loader.sv
// Loads config_module's scan chain from a host byte stream and holds the core in reset until the chain is full.
// Optional readback check of the loaded chain is built when SCAN_VERIFY_EN is defined.
module scan_cfg_loader #(
  parameter int CHAIN_BITS = 1144,
  parameter int SHIFT_DIV  = 1,
  parameter int CNT_BITS   = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  scan_cfg_loader_if.slave host,
  output logic             cfg_scan_reset,
  output logic             cfg_scan_en,
  output logic             cfg_scan_in,
  input  logic             cfg_scan_out,
  output logic             core_reset,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       dbg_state
);

  localparam int DIV_W = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(SHIFT_DIV - 1);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(CHAIN_BITS - 1);
  localparam logic                EN_FIRST = (SHIFT_DIV == 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_WAIT_BYTE = 3'd2,
    S_SHIFT     = 3'd3,
`ifdef SCAN_VERIFY_EN
    S_VERIFY    = 3'd4,
`endif
    S_FINISH    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          sbyte_q, sbyte_d;
  logic                in_ready_q, in_ready_d;
  logic                scan_reset_q, scan_reset_d;
  logic                scan_en_q, scan_en_d;
  logic                scan_in_q, scan_in_d;
  logic                core_reset_q, core_reset_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

`ifdef SCAN_VERIFY_EN
  logic [7:0] crc_q, crc_d;
  logic [7:0] crc_v_q, crc_v_d;
  logic [7:0] crc_v_nx;
  logic       err_q, err_d;
  logic       mismatch;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction
`else
  logic unused_scan_out;
  assign unused_scan_out = cfg_scan_out;
`endif

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    div_d        = div_q;
    bit_idx_d    = bit_idx_q;
    sbyte_d      = sbyte_q;
    in_ready_d   = in_ready_q;
    scan_reset_d = scan_reset_q;
    scan_en_d    = 1'b0;
    scan_in_d    = scan_in_q;
    core_reset_d = core_reset_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
`ifdef SCAN_VERIFY_EN
    crc_d        = crc_q;
    crc_v_d      = crc_v_q;
    crc_v_nx     = crc8_step(crc_v_q, cfg_scan_out);
    err_d        = err_q;
    mismatch     = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_CLEAR;
          core_reset_d = 1'b1;
          busy_d       = 1'b1;
          scan_reset_d = 1'b1;
          div_d        = '0;
          bit_cnt_d    = '0;
`ifdef SCAN_VERIFY_EN
          err_d        = 1'b0;
          crc_d        = 8'h00;
`endif
        end
      end

      // div counter doubles as the two-cycle scan_reset timer
      S_CLEAR: begin
        if (div_q == DIV_W'(1)) begin
          state_d      = S_WAIT_BYTE;
          scan_reset_d = 1'b0;
          in_ready_d   = 1'b1;
          bit_cnt_d    = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_WAIT_BYTE: begin
        if (host.in_valid && in_ready_q) begin
          state_d    = S_SHIFT;
          in_ready_d = 1'b0;
          sbyte_d    = host.in_data;
          scan_in_d  = host.in_data[0];
          bit_idx_d  = '0;
          div_d      = '0;
          scan_en_d  = EN_FIRST;
        end
      end

      S_SHIFT: begin
        if (scan_en_q) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef SCAN_VERIFY_EN
          crc_d     = crc8_step(crc_q, scan_in_q);
`endif
          if (bit_cnt_q == CNT_LAST) begin
`ifdef SCAN_VERIFY_EN
            state_d   = S_VERIFY;
            bit_cnt_d = '0;
            crc_v_d   = 8'h00;
            div_d     = '0;
            scan_en_d = EN_FIRST;
`else
            state_d      = S_FINISH;
            done_d       = 1'b1;
            core_reset_d = 1'b0;
`endif
          end else if (bit_idx_q == 3'd7) begin
            state_d    = S_WAIT_BYTE;
            in_ready_d = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            sbyte_d   = {1'b0, sbyte_q[7:1]};
            scan_in_d = sbyte_q[1];
            div_d     = '0;
            scan_en_d = EN_FIRST;
          end
        end else begin
          div_d     = div_q + 1'b1;
          scan_en_d = (DIV_W'(div_q + 1'b1) == DIV_LAST);
        end
      end

`ifdef SCAN_VERIFY_EN
      S_VERIFY: begin
        if (scan_en_q) begin
          crc_v_d   = crc_v_nx;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_LAST) begin
            mismatch     = (crc_v_nx != crc_q);
            err_d        = err_q | mismatch;
            state_d      = S_FINISH;
            done_d       = 1'b1;
            core_reset_d = err_q | mismatch;
          end else begin
            div_d     = '0;
            scan_en_d = EN_FIRST;
          end
        end else begin
          div_d     = div_q + 1'b1;
          scan_en_d = (DIV_W'(div_q + 1'b1) == DIV_LAST);
        end
      end
`endif

      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      div_q        <= '0;
      bit_idx_q    <= '0;
      sbyte_q      <= '0;
      in_ready_q   <= 1'b0;
      scan_reset_q <= 1'b0;
      scan_en_q    <= 1'b0;
      scan_in_q    <= 1'b0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef SCAN_VERIFY_EN
      crc_q        <= 8'h00;
      crc_v_q      <= 8'h00;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      div_q        <= div_d;
      bit_idx_q    <= bit_idx_d;
      sbyte_q      <= sbyte_d;
      in_ready_q   <= in_ready_d;
      scan_reset_q <= scan_reset_d;
      scan_en_q    <= scan_en_d;
      scan_in_q    <= scan_in_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef SCAN_VERIFY_EN
      crc_q        <= crc_d;
      crc_v_q      <= crc_v_d;
      err_q        <= err_d;
`endif
    end
  end

  assign host.in_ready  = in_ready_q;
  assign cfg_scan_reset = scan_reset_q;
  assign cfg_scan_en    = scan_en_q;
  assign core_reset     = core_reset_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign dbg_state      = state_q;

`ifdef SCAN_VERIFY_EN
  // Recirculation must present the chain's current tail at the strobe, so scan_in bypasses its flop here.
  assign cfg_scan_in = (state_q == S_VERIFY) ? cfg_scan_out : scan_in_q;
  assign err         = err_q;
`else
  assign cfg_scan_in = scan_in_q;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_scan_cfg_loader.sv
// Bench for scan_cfg_loader: two instances (16-bit chain / div 1, 12-bit chain / div 3) with behavioural scan chains.
// Covers SCAN_VERIFY_EN builds as well as the default build.
module tb_scan_cfg_loader;
  localparam int LEN0 = 16;
  localparam int LEN1 = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] start, sr, en, si, so, cr, bz, dn, er;
  logic [2:0] st0, st1;

  always #5 clk = ~clk;

  scan_cfg_loader_if h0();
  scan_cfg_loader_if h1();

  scan_cfg_loader #(.CHAIN_BITS(LEN0), .SHIFT_DIV(1), .CNT_BITS(5)) dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .host(h0),
    .cfg_scan_reset(sr[0]), .cfg_scan_en(en[0]), .cfg_scan_in(si[0]), .cfg_scan_out(so[0]),
    .core_reset(cr[0]), .busy(bz[0]), .done(dn[0]), .err(er[0]), .dbg_state(st0)
  );

  scan_cfg_loader #(.CHAIN_BITS(LEN1), .SHIFT_DIV(3), .CNT_BITS(4)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .host(h1),
    .cfg_scan_reset(sr[1]), .cfg_scan_en(en[1]), .cfg_scan_in(si[1]), .cfg_scan_out(so[1]),
    .core_reset(cr[1]), .busy(bz[1]), .done(dn[1]), .err(er[1]), .dbg_state(st1)
  );

  // Behavioural scan chains; corrupt[] flips the third bit shifted in after a scan_reset.
  logic [15:0] chain0;
  logic [11:0] chain1;
  int          sh0, sh1;
  logic [1:0]  corrupt;
  assign so = {chain1[0], chain0[0]};

  always @(posedge clk) begin
    if (sr[0]) begin
      chain0 <= '0;
      sh0    <= 0;
    end else if (en[0]) begin
      chain0 <= {si[0] ^ (corrupt[0] && sh0 == 2), chain0[15:1]};
      sh0    <= sh0 + 1;
    end
    if (sr[1]) begin
      chain1 <= '0;
      sh1    <= 0;
    end else if (en[1]) begin
      chain1 <= {si[1] ^ (corrupt[1] && sh1 == 2), chain1[11:1]};
      sh1    <= sh1 + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard state
  logic [0:0] exp_q0[$];
  logic [0:0] exp_q1[$];
  int   strobes[2], vstrobes[2], ready_cyc[2], sr_cyc[2], done_cnt[2], last_cyc[2], pushed[2];
  logic exp_err[2], exp_cr[2];
  int   cyc = 0;
  logic m_exp;
  bit   m_have;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic rdy(input int s);
    return (s == 0) ? h0.in_ready : h1.in_ready;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        if (rdy(s)) ready_cyc[s]++;
        if (sr[s]) begin
          sr_cyc[s]++;
          chk("clear_busy_core_reset", {30'd0, bz[s], cr[s]}, 32'd3);
        end
        if (en[s]) begin
          m_have = 1'b0;
          if (s == 0 && exp_q0.size() > 0) begin m_exp = exp_q0.pop_front(); m_have = 1'b1; end
          if (s == 1 && exp_q1.size() > 0) begin m_exp = exp_q1.pop_front(); m_have = 1'b1; end
          if (m_have) begin
            chk("scan_bit", si[s], m_exp);
            if (strobes[s] > 0)
              chk("strobe_gap", cyc - last_cyc[s],
                  (strobes[s] % 8 == 0) ? ((s == 0) ? 2 : 4) : ((s == 0) ? 1 : 3));
            strobes[s]++;
            last_cyc[s] = cyc;
          end else begin
`ifdef SCAN_VERIFY_EN
            chk("recirculate", si[s], so[s]);
            vstrobes[s]++;
`else
            chk("extra_strobe", en[s], 1'b0);
`endif
          end
        end
        if (dn[s]) begin
          done_cnt[s]++;
          chk("done_core_reset", cr[s], exp_cr[s]);
          chk("done_err", er[s], exp_err[s]);
        end
      end
    end
  end

  // Driver tasks
  task automatic drive(input int s, input logic [7:0] d, input logic v);
    if (s == 0) begin h0.in_data = d; h0.in_valid = v; end
    else        begin h1.in_data = d; h1.in_valid = v; end
  endtask

  task automatic pulse_start(input int s);
    @(posedge clk); #1 start[s] = 1'b1;
    @(posedge clk); #1 start[s] = 1'b0;
  endtask

  task automatic start_load(input int s);
    strobes[s] = 0; vstrobes[s] = 0; ready_cyc[s] = 0; sr_cyc[s] = 0;
    done_cnt[s] = 0; pushed[s] = 0;
    if (s == 0) exp_q0.delete(); else exp_q1.delete();
    pulse_start(s);
  endtask

  task automatic send_byte(input int s, input logic [7:0] b);
    bit got;
    int len;
    len = (s == 0) ? LEN0 : LEN1;
    drive(s, b, 1'b1);
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (rdy(s)) got = 1'b1;
    end
    chk("handshake", got, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (pushed[s] < len) begin
        if (s == 0) exp_q0.push_back(b[i]); else exp_q1.push_back(b[i]);
        pushed[s]++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run_load(input int s, input logic [7:0] b0, input logic [7:0] b1, input bit poke,
                          input int exp_strobes, input logic [15:0] exp_chain);
    bit got;
    start_load(s);
    send_byte(s, b0);
    if (poke) begin
      drive(s, b1, 1'b1);
      pulse_start(s);
    end
    send_byte(s, b1);
    drive(s, 8'h00, 1'b0);
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk); #1;
      if (done_cnt[s] > 0) got = 1'b1;
    end
    chk("done_seen", got, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    chk("strobe_count", strobes[s], exp_strobes);
`ifdef SCAN_VERIFY_EN
    chk("verify_strobes", vstrobes[s], exp_strobes);
`else
    chk("verify_strobes", vstrobes[s], 0);
`endif
    chk("ready_cycles", ready_cyc[s], 2);
    chk("scan_reset_cycles", sr_cyc[s], 2);
    chk("done_pulses", done_cnt[s], 1);
    chk("chain_contents", (s == 0) ? chain0 : {4'h0, chain1}, exp_chain);
    chk("exp_queue_empty", (s == 0) ? exp_q0.size() : exp_q1.size(), 0);
    chk("idle_busy_state", {28'd0, bz[s], (s == 0) ? st0 : st1}, 32'd0);
    chk("idle_core_reset", cr[s], exp_cr[s]);
    chk("idle_err", er[s], exp_err[s]);
  endtask

  task automatic check_reset_vals();
    chk("rst_outputs_dut0", {h0.in_ready, sr[0], en[0], si[0], cr[0], bz[0], dn[0], er[0], st0}, 11'b00001000000);
    chk("rst_outputs_dut1", {h1.in_ready, sr[1], en[1], si[1], cr[1], bz[1], dn[1], er[1], st1}, 11'b00001000000);
  endtask

  typedef struct {
    int         sel;
    logic [7:0] b0;
    logic [7:0] b1;
    bit         poke;
    int         exp_strobes;
    logic [15:0] exp_chain;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1);
  end

  initial begin
    bit got;
    vecs[0] = '{0, 8'hA5, 8'h3C, 1'b0, 16, 16'h3CA5};
    vecs[1] = '{0, 8'h00, 8'hFF, 1'b0, 16, 16'hFF00};
    vecs[2] = '{0, 8'h5A, 8'hC3, 1'b1, 16, 16'hC35A};
    vecs[3] = '{1, 8'hFF, 8'h0F, 1'b0, 12, 16'h0FFF};
    vecs[4] = '{1, 8'h12, 8'h34, 1'b1, 12, 16'h0412};
    vecs[5] = '{1, 8'hA5, 8'h3C, 1'b0, 12, 16'h0CA5};

    start = '0;
    corrupt = '0;
    for (int s = 0; s < 2; s++) begin
      exp_err[s] = 1'b0;
      exp_cr[s]  = 1'b0;
      drive(s, 8'h00, 1'b0);
    end

    repeat (3) @(negedge clk);
    check_reset_vals();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++)
      run_load(vecs[v].sel, vecs[v].b0, vecs[v].b1, vecs[v].poke, vecs[v].exp_strobes, vecs[v].exp_chain);

    // Asynchronous reset during the fifth bit of the second byte, then a clean reload
    start_load(0);
    send_byte(0, 8'hA5);
    send_byte(0, 8'h3C);
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(posedge clk); #2;
      if (strobes[0] >= 12) got = 1'b1;
    end
    chk("midload_reached", got, 1'b1);
    reset = 1'b0;
    #1;
    check_reset_vals();
    exp_q0.delete();
    drive(0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    run_load(vecs[0].sel, vecs[0].b0, vecs[0].b1, vecs[0].poke, vecs[0].exp_strobes, vecs[0].exp_chain);

`ifdef SCAN_VERIFY_EN
    // Corrupted chain: readback CRC differs, core stays in reset and err stays set in idle
    corrupt[1] = 1'b1;
    exp_err[1] = 1'b1;
    exp_cr[1]  = 1'b1;
    run_load(1, 8'hA5, 8'h3C, 1'b0, 12, 16'h0CA1);
    corrupt[1] = 1'b0;
    exp_err[1] = 1'b0;
    exp_cr[1]  = 1'b0;
    run_load(1, 8'hA5, 8'h3C, 1'b0, 12, 16'h0CA5);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
